// File: rtl/power_request_if.sv
// power_request_if: software requests, fault status, sequencer handshake and status flags of the power request controller
interface power_request_if;
  logic soft_power_up;
  logic soft_power_down;
  logic sys_fault;
  logic power_up_done;
  logic power_down_done;
  logic power_up;
  logic power_down;
  logic fault_lockout;
  logic req_timeout;
  modport master (
    input  soft_power_up, soft_power_down, sys_fault, power_up_done, power_down_done,
    output power_up, power_down, fault_lockout, req_timeout
  );
  modport slave (
    output soft_power_up, soft_power_down, sys_fault, power_up_done, power_down_done,
    input  power_up, power_down, fault_lockout, req_timeout
  );
endinterface

// File: rtl/power_request_ctrl.sv
// power_request_ctrl: debounced button / soft request arbiter driving power_up/power_down to a sequencer; ports clk, reset_n (async active-low), power_button (raw async), bus (power_request_if.master: soft_power_up/down, sys_fault, power_up_done/down_done in; power_up/down, fault_lockout, req_timeout out); define POWER_AUTO_RESTART_EN to re-request power-up after a fault lockout that interrupted an up state
module power_request_ctrl #(
  parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd1000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd4000000,
  parameter logic [31:0] COOLDOWN_CYCLES   = 32'd10000000,
  parameter logic [31:0] ACK_TIMEOUT       = 32'd100000
) (
  input logic clk,
  input logic reset_n,
  input logic power_button,
  power_request_if.master bus
);
  typedef enum logic [2:0] {DOWN, REQ_UP, UP, REQ_DOWN, COOLDOWN} state_t;
  state_t state, state_n;
  logic sync1, sync2, deb, deb_d;
  logic [31:0] deb_cnt, press_cnt, timer, timer_n;
  logic fault, fault_n, tmo, tmo_n, dn_min, dn_min_n;
  logic short_press, long_press, up_req, dn_req;
`ifdef POWER_AUTO_RESTART_EN
  logic restart, restart_n;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb <= 1'b0;
      deb_d <= 1'b0;
      deb_cnt <= '0;
      press_cnt <= '0;
    end else begin
      sync1 <= power_button;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) deb_cnt <= '0;
      else if (deb_cnt >= DEBOUNCE_CYCLES - 32'd1) begin
        deb <= sync2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 32'd1;
      // saturates at LONG_PRESS_CYCLES, which marks "long press already fired"
      press_cnt <= !deb ? '0 : (press_cnt == LONG_PRESS_CYCLES) ? press_cnt : press_cnt + 32'd1;
    end
  assign long_press  = deb && press_cnt == LONG_PRESS_CYCLES - 32'd1;
  assign short_press = !deb && deb_d && press_cnt != LONG_PRESS_CYCLES;
  assign up_req = (short_press && state == DOWN) || bus.soft_power_up;
  assign dn_req = (short_press && (state == REQ_UP || state == UP)) || long_press || bus.soft_power_down;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= DOWN;
      timer <= '0;
      fault <= 1'b0;
      tmo <= 1'b0;
      dn_min <= 1'b0;
`ifdef POWER_AUTO_RESTART_EN
      restart <= 1'b0;
`endif
    end else begin
      state <= state_n;
      timer <= timer_n;
      fault <= fault_n;
      tmo <= tmo_n;
      dn_min <= dn_min_n;
`ifdef POWER_AUTO_RESTART_EN
      restart <= restart_n;
`endif
    end
  always_comb begin
    state_n = state;
    timer_n = timer;
    fault_n = fault;
    tmo_n = tmo;
    dn_min_n = 1'b0;
`ifdef POWER_AUTO_RESTART_EN
    restart_n = restart;
`endif
    case (state)
      DOWN:
        if (bus.sys_fault) begin
          state_n = COOLDOWN;
          timer_n = COOLDOWN_CYCLES;
          fault_n = 1'b1;
        end else if (up_req && !dn_req) begin
          state_n = REQ_UP;
          timer_n = ACK_TIMEOUT;
          tmo_n = 1'b0;
        end
      REQ_UP, UP:
        if (bus.sys_fault || dn_req || (state == REQ_UP && !bus.power_up_done && timer == '0)) begin
          state_n = REQ_DOWN;
          timer_n = ACK_TIMEOUT;
          fault_n = fault || bus.sys_fault;
          tmo_n = tmo || (!bus.sys_fault && !dn_req);
`ifdef POWER_AUTO_RESTART_EN
          restart_n = restart || bus.sys_fault;
`endif
        end else if (state == REQ_UP) begin
          state_n = bus.power_up_done ? UP : REQ_UP;
          timer_n = timer - 32'd1;
        end
      REQ_DOWN: begin
        dn_min_n = 1'b1;
        fault_n = fault || bus.sys_fault;
        // dn_min guarantees power_down is held for at least two cycles
        if (dn_min && bus.power_down_done) begin
          state_n = fault_n ? COOLDOWN : DOWN;
          timer_n = COOLDOWN_CYCLES;
        end else if (timer == '0) tmo_n = 1'b1;
        else timer_n = timer - 32'd1;
      end
      COOLDOWN:
        if (bus.sys_fault) timer_n = COOLDOWN_CYCLES;
        else if (timer == '0) begin
          fault_n = 1'b0;
`ifdef POWER_AUTO_RESTART_EN
          state_n = restart ? REQ_UP : DOWN;
          timer_n = ACK_TIMEOUT;
          restart_n = 1'b0;
`else
          state_n = DOWN;
`endif
        end else timer_n = timer - 32'd1;
      default: state_n = DOWN;
    endcase
  end
  always_comb begin
    bus.power_up = state == REQ_UP || state == UP;
    bus.power_down = state == REQ_DOWN;
    bus.fault_lockout = state == COOLDOWN;
    bus.req_timeout = tmo;
  end
endmodule

// File: tb/tb_power_request_ctrl.sv
// tb_power_request_ctrl: directed self-checking bench for power_request_ctrl
module tb_power_request_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic power_button;
  int errors = 0;
  int checks = 0;
  power_request_if bus();
  power_request_ctrl #(
    .DEBOUNCE_CYCLES(32'd4),
    .LONG_PRESS_CYCLES(32'd20),
    .COOLDOWN_CYCLES(32'd10),
    .ACK_TIMEOUT(32'd50)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .power_button(power_button),
    .bus(bus.master)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    power_button = 1'b0;
    bus.soft_power_up = 1'b0;
    bus.soft_power_down = 1'b0;
    bus.sys_fault = 1'b0;
    bus.power_up_done = 1'b0;
    bus.power_down_done = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic go_up;
    bus.soft_power_up = 1'b1;
    tick(1);
    bus.soft_power_up = 1'b0;
    bus.power_up_done = 1'b1;
    tick(2);
    bus.power_up_done = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    power_button = 1'b1;
    bus.soft_power_up = 1'b1;
    bus.soft_power_down = 1'b0;
    bus.sys_fault = 1'b0;
    bus.power_up_done = 1'b0;
    bus.power_down_done = 1'b0;
    tick(3);
    checks++; if (bus.power_up !== 1'b0) begin errors++; $display("FAIL reset_power_up: got %b want 0", bus.power_up); end
    checks++; if (bus.power_down !== 1'b0) begin errors++; $display("FAIL reset_power_down: got %b want 0", bus.power_down); end
    checks++; if (bus.fault_lockout !== 1'b0) begin errors++; $display("FAIL reset_fault_lockout: got %b want 0", bus.fault_lockout); end
    checks++; if (bus.req_timeout !== 1'b0) begin errors++; $display("FAIL reset_req_timeout: got %b want 0", bus.req_timeout); end
  endtask

  task automatic test_glitch;
    logic seen;
    do_reset();
    seen = 1'b0;
    power_button = 1'b1;
    tick(3);
    power_button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | bus.power_up;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_no_event: power_up seen %b want 0", seen); end
  endtask

  task automatic test_short_press;
    int first;
    do_reset();
    first = 0;
    power_button = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 10) power_button = 1'b0;
      if (bus.power_up === 1'b1 && first == 0) first = i;
    end
    checks++; if (first != 17) begin errors++; $display("FAIL short_press_latency: got %0d want 17", first); end
    bus.power_up_done = 1'b1;
    tick(2);
    bus.power_up_done = 1'b0;
    tick(3);
    checks++; if (bus.power_up !== 1'b1) begin errors++; $display("FAIL short_press_up_state: power_up %b want 1", bus.power_up); end
    checks++; if (bus.power_down !== 1'b0) begin errors++; $display("FAIL short_press_no_down: power_down %b want 0", bus.power_down); end
  endtask

  task automatic test_long_press;
    int first;
    logic seen;
    do_reset();
    go_up();
    checks++; if (bus.power_up !== 1'b1) begin errors++; $display("FAIL long_press_setup: power_up %b want 1", bus.power_up); end
    first = 0;
    power_button = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (bus.power_down === 1'b1 && first == 0) begin
        first = i;
        bus.power_down_done = 1'b1;
      end
    end
    power_button = 1'b0;
    checks++; if (first != 26) begin errors++; $display("FAIL long_press_latency: got %0d want 26", first); end
    bus.power_down_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      seen = seen | bus.power_up | bus.power_down;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL long_press_release_event: activity %b want 0", seen); end
  endtask

  task automatic test_fault_cooldown;
    int n;
    logic active;
    do_reset();
    go_up();
    bus.sys_fault = 1'b1;
    tick(1);
    checks++; if (bus.power_down !== 1'b1) begin errors++; $display("FAIL fault_power_down: got %b want 1", bus.power_down); end
    checks++; if (bus.power_up !== 1'b0) begin errors++; $display("FAIL fault_power_up: got %b want 0", bus.power_up); end
    tick(4);
    bus.sys_fault = 1'b0;
    bus.power_down_done = 1'b1;
    for (int i = 0; i < 10 && bus.fault_lockout !== 1'b1; i++) tick(1);
    checks++; if (bus.fault_lockout !== 1'b1) begin errors++; $display("FAIL fault_lockout_entry: got %b want 1", bus.fault_lockout); end
    n = 0;
    active = 1'b0;
    while (bus.fault_lockout === 1'b1 && n < 100) begin
      n++;
      active = active | bus.power_up | bus.power_down;
      bus.soft_power_up = (n == 3);
      tick(1);
    end
    bus.soft_power_up = 1'b0;
    bus.power_down_done = 1'b0;
    checks++; if (n != 11) begin errors++; $display("FAIL fault_lockout_cycles: got %0d want 11", n); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL fault_lockout_outputs: requests %b want 0", active); end
`ifdef POWER_AUTO_RESTART_EN
    checks++; if (bus.power_up !== 1'b1) begin errors++; $display("FAIL auto_restart: power_up %b want 1", bus.power_up); end
`else
    tick(5);
    checks++; if (bus.power_up !== 1'b0) begin errors++; $display("FAIL no_restart: power_up %b want 0", bus.power_up); end
`endif
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    bus.soft_power_up = 1'b1;
    tick(1);
    bus.soft_power_up = 1'b0;
    n = 0;
    while (bus.power_up === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
    checks++; if (n != 51) begin errors++; $display("FAIL timeout_up_cycles: got %0d want 51", n); end
    checks++; if (bus.req_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", bus.req_timeout); end
    checks++; if (bus.power_down !== 1'b1) begin errors++; $display("FAIL timeout_power_down: got %b want 1", bus.power_down); end
    bus.power_down_done = 1'b1;
    tick(3);
    bus.power_down_done = 1'b0;
    tick(1);
    checks++; if (bus.power_down !== 1'b0) begin errors++; $display("FAIL timeout_down_exit: power_down %b want 0", bus.power_down); end
    checks++; if (bus.req_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", bus.req_timeout); end
    bus.soft_power_up = 1'b1;
    tick(1);
    bus.soft_power_up = 1'b0;
    checks++; if (bus.req_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", bus.req_timeout); end
    checks++; if (bus.power_up !== 1'b1) begin errors++; $display("FAIL timeout_reaccept: power_up %b want 1", bus.power_up); end
  endtask

  task automatic test_conflict_and_async_reset;
    do_reset();
    bus.soft_power_up = 1'b1;
    bus.soft_power_down = 1'b1;
    tick(1);
    bus.soft_power_up = 1'b0;
    bus.soft_power_down = 1'b0;
    tick(3);
    checks++; if ({bus.power_up, bus.power_down} !== 2'b00) begin errors++; $display("FAIL conflict_outputs: got %b want 00", {bus.power_up, bus.power_down}); end
    bus.soft_power_up = 1'b1;
    tick(1);
    bus.soft_power_up = 1'b0;
    checks++; if (bus.power_up !== 1'b1) begin errors++; $display("FAIL async_setup: power_up %b want 1", bus.power_up); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.power_up !== 1'b0) begin errors++; $display("FAIL async_reset_power_up: got %b want 0", bus.power_up); end
    tick(1);
    reset_n = 1'b1;
    tick(3);
    checks++; if (bus.power_up !== 1'b0) begin errors++; $display("FAIL reset_stays_down: power_up %b want 0", bus.power_up); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_fault_cooldown();
    test_timeout();
    test_conflict_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/power_request_ctrl.md
POWER_REQUEST_CTRL -- requirements
Module: power_request_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEBOUNCE_CYCLES, 32'd1000, stable cycles to accept a button level.
REQ-002 LONG_PRESS_CYCLES, 32'd4000000, debounced hold time for forced power-down.
REQ-003 COOLDOWN_CYCLES, 32'd10000000, fault-free cycles before lockout release.
REQ-004 ACK_TIMEOUT, 32'd100000, cycles allowed for sequencer acknowledge.
REQ-005 Ports SHALL be: clk  input  1  system clock, all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 power_button  input  1  raw front-panel button, active-high, asynchronous.
REQ-008 soft_power_up / soft_power_down  input  1 each  single-cycle software requests.
REQ-009 sys_fault  input  1  synchronous level, high = supply/thermal fault.
REQ-010 power_up_done / power_down_done  input  1 each  sequencer status levels.
REQ-011 power_up / power_down  output  1 each  registered request levels to sequencer, never both high.
REQ-012 fault_lockout  output  1  high in COOLDOWN.
REQ-013 req_timeout  output  1  sticky acknowledge-timeout flag.

Function
REQ-014 Button SHALL pass a 2-flop synchronizer; debounced level SHALL change only after synced level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Press counter SHALL start at debounced rise; at count == LONG_PRESS_CYCLES while held, one long-press event SHALL fire; release before that SHALL fire one short-press event; release after a long press SHALL fire nothing.
REQ-016 Up request = short press in DOWN, or soft_power_up; down request = short press in REQ_UP/UP, long press, or soft_power_down.
REQ-017 Priority SHALL be sys_fault > down request > up request; simultaneous up and down requests SHALL resolve as down.
REQ-018 States: DOWN, REQ_UP, UP, REQ_DOWN, COOLDOWN; outputs registered, asserted the cycle after the triggering event.
REQ-019 DOWN: outputs low; up request with sys_fault low -> REQ_UP, timer = ACK_TIMEOUT; sys_fault -> COOLDOWN.
REQ-020 REQ_UP: power_up=1; power_up_done -> UP; down request -> REQ_DOWN; sys_fault -> REQ_DOWN with fault latched; timer reaching 0 -> set req_timeout, -> REQ_DOWN.
REQ-021 UP: power_up=1; down request -> REQ_DOWN; sys_fault -> REQ_DOWN with fault latched; up requests ignored.
REQ-022 REQ_DOWN: power_down=1 for minimum 2 cycles and until power_down_done; timer reloads ACK_TIMEOUT on entry; expiry sets req_timeout, power_down stays high; exit -> COOLDOWN if fault latched, else DOWN.
REQ-023 COOLDOWN: fault_lockout=1, both requests low, all button/soft requests discarded; timer = COOLDOWN_CYCLES while sys_fault high, decrements while low; at 0 -> DOWN and clear fault latch.
REQ-024 req_timeout SHALL clear when the next request is accepted in DOWN.
REQ-025 Timers SHALL be 32-bit unsigned, decrement saturating at 0, no wrap.

Reset
REQ-026 reset_n low SHALL immediately force state DOWN, power_up=0, power_down=0, fault_lockout=0, req_timeout=0, debounced level 0, all counters and latches 0, including mid-sequence.
REQ-027 First button event after reset_n release SHALL need a full DEBOUNCE_CYCLES.

Configuration
REQ-028 Macro POWER_AUTO_RESTART_EN: defined -> fault from UP or REQ_UP records restart flag; COOLDOWN expiry with flag set -> REQ_UP (flag cleared, timer = ACK_TIMEOUT); undefined -> COOLDOWN expiry always -> DOWN, no flag logic.

Verification (bench: DEBOUNCE=4, LONG=20, COOLDOWN=10, ACK_TIMEOUT=50)
REQ-029 Button high 3 cycles then low -> no event, power_up stays 0; high 10 cycles then low -> power_up=1, held until power_up_done, state UP.
REQ-030 In UP, hold button 30 cycles -> power_down=1 at debounce+20 cycles, before release; release produces no extra event.
REQ-031 In UP, sys_fault 1 for 5 cycles -> power_down=1, after power_down_done fault_lockout=1 for 10 cycles after fault drop; soft_power_up during lockout ignored.
REQ-032 soft_power_up with power_up_done held 0 -> req_timeout=1 after 50 cycles, power_down=1; next accepted soft_power_up clears req_timeout.
REQ-033 soft_power_up and soft_power_down same cycle in DOWN -> outputs stay 0; reset_n pulsed low in REQ_UP -> power_up=0 immediately.
REQ-034 With POWER_AUTO_RESTART_EN defined, fault in UP -> power_up re-asserted 10 cycles after sys_fault falls and power_down_done; undefined -> stays DOWN.
